// File: rtl/sar_search_ctrl.sv
// ---------------------------------------------------------------------------
// sar_search_ctrl
//
// Successive-approximation controller. It drives a trial operand into an
// external combinational magnitude comparator and reads back lt/gt/eq. One
// result bit is resolved per clock, MSB first, to recover the unknown
// operand held on the comparator's other input.
//
// Optional feature (compile-time macro SAR_EARLY_EXIT_EN):
//   defined   - a decided eq ends the search at once (lower bits stay 0)
//   undefined - eq only keeps the bit; the search always runs WIDTH steps
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   request a search (sampled only in IDLE)
//   cmp_lt   in   comparator: a <  trial
//   cmp_gt   in   comparator: a >  trial
//   cmp_eq   in   comparator: a == trial
//   trial    out  registered operand driven to comparator input b
//   busy     out  high while searching
//   done     out  one-cycle pulse when result is valid
//   result   out  search result, held until the next done
//   exact    out  eq was seen during the last search (valid with done)
//   cmp_err  out  lt/gt/eq not one-hot in some step (valid with done)
// ---------------------------------------------------------------------------
module sar_search_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_lt,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             exact,
    output logic             cmp_err
);

    localparam int unsigned     IdxW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IdxW-1:0] IdxMsb   = IdxW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] TrialMsb = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StDone
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_trial;
    logic [IdxW-1:0]  r_bit_idx;
    logic             r_exact_acc;
    logic             r_err_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_exact;
    logic             r_cmp_err;
    logic             r_busy;
    logic             r_done;

    logic             w_none;
    logic             w_err;
    logic             w_dec_lt;
    logic             w_last;
    logic             w_stop;
    logic [WIDTH-1:0] w_bit_mask;
    logic [WIDTH-1:0] w_trial_dec;
    logic [WIDTH-1:0] w_trial_next;
    logic             w_exact_acc;
    logic             w_err_acc;

    // Step decision: priority lt > eq > gt, and "none set" decides as lt.
    always_comb begin
        w_none       = ~(cmp_lt | cmp_gt | cmp_eq);
        w_err        = w_none | (cmp_lt & cmp_gt) | (cmp_lt & cmp_eq) | (cmp_gt & cmp_eq);
        w_dec_lt     = cmp_lt | w_none;
        w_last       = (r_bit_idx == '0);
        w_bit_mask   = WIDTH'(1) << r_bit_idx;
        w_trial_dec  = w_dec_lt ? (r_trial & ~w_bit_mask) : r_trial;
        // Next trial sets the bit just below the one being decided.
        w_trial_next = w_last ? w_trial_dec : (w_trial_dec | (w_bit_mask >> 1));
        w_exact_acc  = r_exact_acc | cmp_eq;
        w_err_acc    = r_err_acc | w_err;
    end

`ifdef SAR_EARLY_EXIT_EN
    logic w_dec_eq;

    // eq only ends the search when it is the decided outcome (lt not set).
    always_comb begin
        w_dec_eq = ~cmp_lt & cmp_eq;
        w_stop   = w_last | w_dec_eq;
    end
`else
    always_comb begin
        w_stop = w_last;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_trial     <= '0;
            r_bit_idx   <= '0;
            r_exact_acc <= 1'b0;
            r_err_acc   <= 1'b0;
            r_result    <= '0;
            r_exact     <= 1'b0;
            r_cmp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_trial     <= TrialMsb;
                        r_bit_idx   <= IdxMsb;
                        r_exact_acc <= 1'b0;
                        r_err_acc   <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= StSearch;
                    end
                end
                StSearch: begin
                    r_exact_acc <= w_exact_acc;
                    r_err_acc   <= w_err_acc;
                    if (w_stop) begin
                        // On an early eq exit w_trial_dec equals the current trial.
                        r_trial   <= w_trial_dec;
                        r_result  <= w_trial_dec;
                        r_exact   <= w_exact_acc;
                        r_cmp_err <= w_err_acc;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= StDone;
                    end else begin
                        r_trial   <= w_trial_next;
                        r_bit_idx <= r_bit_idx - IdxW'(1);
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign trial   = r_trial;
    assign busy    = r_busy;
    assign done    = r_done;
    assign result  = r_result;
    assign exact   = r_exact;
    assign cmp_err = r_cmp_err;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sar_search_ctrl
//
// Scoreboard bench for sar_search_ctrl (WIDTH=16). The driver pushes the
// expected outcome of each search; a negedge monitor pops and compares it
// whenever done is seen, and also checks the per-step trial sequence.
// Latency is counted in negedges from the first busy sample to done.
// ---------------------------------------------------------------------------
module tb_sar_search_ctrl;

    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] res;
        logic         exact;
        logic         err;
        int           lat;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         cmp_lt;
    logic         cmp_gt;
    logic         cmp_eq;
    logic [W-1:0] trial;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         exact;
    logic         cmp_err;

    logic [W-1:0] a;
    logic         fault_en;

    exp_t         exp_q[$];
    logic [W-1:0] trial_q[$];

    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int neg_cnt  = 0;
    int start_neg = 0;
    int busy_cycles = 0;
    logic prev_busy = 1'b0;

    sar_search_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .cmp_lt  (cmp_lt),
        .cmp_gt  (cmp_gt),
        .cmp_eq  (cmp_eq),
        .trial   (trial),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .exact   (exact),
        .cmp_err (cmp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal comparator, with an injectable all-zero fault at trial 0x2000.
    always_comb begin
        cmp_lt = 1'b0;
        cmp_gt = 1'b0;
        cmp_eq = 1'b0;
        if (!(fault_en && busy && trial == 16'h2000)) begin
            cmp_lt = (a < trial);
            cmp_gt = (a > trial);
            cmp_eq = (a == trial);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: trial sequence while busy, scoreboard compare on done.
    always @(negedge clk) begin
        exp_t e;
        if (busy) begin
            if (!prev_busy) begin
                start_neg   = neg_cnt;
                busy_cycles = 0;
            end
            busy_cycles++;
            if (trial_q.size() > 0) check("trial_step", 32'(trial), 32'(trial_q.pop_front()));
        end
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("exact", 32'(exact), 32'(e.exact));
                check("cmp_err", 32'(cmp_err), 32'(e.err));
                check("latency", 32'(neg_cnt - start_neg), 32'(e.lat));
                check("busy_cycles", 32'(busy_cycles), 32'(e.lat));
            end
        end
        prev_busy = busy;
        neg_cnt++;
    end

    task automatic run(input logic [W-1:0] av, input logic [W-1:0] er, input logic ee,
                       input logic eerr, input int lat, input bit mid_start,
                       input bit done_start);
        exp_t e;
        int   target;
        bit   got;
        a       = av;
        e.res   = er;
        e.exact = ee;
        e.err   = eerr;
        e.lat   = lat;
        exp_q.push_back(e);
        target = done_cnt + 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (mid_start) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= target) got = 1'b1;
        end
        if (!got) begin
            check("done_timeout", 32'(got), 32'd1);
            exp_q.delete();
        end
        if (done_start) begin
            // Sampled while in DONE: must be ignored.
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
            #1;
            check("ignored_start_busy", 32'(busy), 32'd0);
            check("ignored_start_done_cnt", 32'(done_cnt), 32'(target));
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat_8000;
        int lat_1234;
`ifdef SAR_EARLY_EXIT_EN
        lat_8000 = 1;
        lat_1234 = 14;
`else
        lat_8000 = 16;
        lat_1234 = 16;
`endif
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        fault_en = 1'b0;
        #1;
        check("rst_trial", 32'(trial), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_exact", 32'(exact), 32'd0);
        check("rst_cmp_err", 32'(cmp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // a=5: full trial sequence.
        trial_q = '{16'h8000, 16'h4000, 16'h2000, 16'h1000, 16'h0800, 16'h0400,
                    16'h0200, 16'h0100, 16'h0080, 16'h0040, 16'h0020, 16'h0010,
                    16'h0008, 16'h0004, 16'h0006, 16'h0005};
        run(16'h0005, 16'h0005, 1'b1, 1'b0, 16, 1'b0, 1'b0);
        check("trial_held", 32'(trial), 32'h0005);
        check("trial_q_drained", 32'(trial_q.size()), 32'd0);

        run(16'h0000, 16'h0000, 1'b0, 1'b0, 16, 1'b0, 1'b0);
        // start re-asserted during SEARCH and during DONE.
        run(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16, 1'b1, 1'b1);
        run(16'h8000, 16'h8000, 1'b1, 1'b0, lat_8000, 1'b0, 1'b0);

        // Comparator outputs all zero at step 3.
        fault_en = 1'b1;
        run(16'h1234, 16'h1234, 1'b1, 1'b1, lat_1234, 1'b0, 1'b0);
        fault_en = 1'b0;

        // Reset at step 8 aborts the search without a done pulse.
        a = 16'h1234;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_trial", 32'(trial), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'd5);

        run(16'h0005, 16'h0005, 1'b1, 1'b0, 16, 1'b0, 1'b0);
        check("final_done_count", 32'(done_cnt), 32'd6);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
